// File: rtl/ppu_pkg.sv
// Shared PPU pipeline definitions: the fetch FSM state type, the bubble
// instruction word and the default reset PC.
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    // sll $0,$0,0
    localparam logic [31:0] PPU_NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] PPU_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : ppu_pkg

// File: rtl/ppu_if_id_reg.sv
// Generic pipeline register for {instr, pc, valid}: hold > load > bubble;
// with no control asserted the contents are kept.
module ppu_if_id_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (!hold) begin
            if (load) begin
                instr_d = instr_in;
                pc_d    = pc_in;
                valid_d = 1'b1;
            end else if (bubble) begin
                instr_d = NOP_WORD;
                pc_d    = pc_in;
                valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc_q    <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule : ppu_if_id_reg

// File: rtl/ppu_fetch_stage.sv
// PPU instruction-fetch stage: PC, imem request, redirect-after-delay-slot and IF/ID.
// Optional `squash` input enabled by defining PPU_IF_SQUASH_EN.
module ppu_fetch_stage
    import ppu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PPU_DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = PPU_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
`ifdef PPU_IF_SQUASH_EN
    input  logic        squash,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic         imem_req_q;
    logic [31:0]  pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  next_pc;
    logic         squash_w;
    logic         complete;
    logic         load_w;
    logic         bubble_w;

`ifdef PPU_IF_SQUASH_EN
    assign squash_w = squash;
`else
    assign squash_w = 1'b0;
`endif

    assign complete = (state_q != ST_BOOT) && imem_ready && !stall;
    assign load_w   = complete && !squash_w;
    assign bubble_w = !stall && !load_w;

    // A redirect that arrived while IF was waiting outranks one arriving now.
    assign next_pc = pend_valid_q ? pend_target_q :
                     branch_taken ? branch_target : pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            unique case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH: if (!imem_ready) state_d = ST_WAIT;
                ST_WAIT:  if (imem_ready) state_d = ST_FETCH;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        fetch_count_d = fetch_count_q;
        if (!stall) begin
            if (complete) begin
                pc_d         = next_pc;
                pend_valid_d = 1'b0;
                if (!squash_w) fetch_count_d = fetch_count_q + 32'd1;
            end else if (branch_taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target;
            end
        end
    end

    // FSM with its registered request output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d != ST_BOOT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    ppu_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall),
        .load     (load_w),
        .bubble   (bubble_w),
        .instr_in (imem_rdata),
        .pc_in    (pc_q),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .valid    (if_id_valid)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;

endmodule : ppu_fetch_stage

// File: tb/tb_ppu_fetch_stage.sv
// Directed bench for ppu_fetch_stage: behavioural reference checked every
// negedge plus literal spot checks; squash scenario when PPU_IF_SQUASH_EN is set.
module tb_ppu_fetch_stage;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        squash_in = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MEM_KEY;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    ppu_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
`ifdef PPU_IF_SQUASH_EN
        .squash        (squash_in),
`endif
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: "active" once one unstalled edge has passed after reset;
    // a fetch completes whenever active, memory ready and not stalled.
    logic        m_active;
    logic [31:0] m_pc, m_redirect, m_count, m_instr, m_ipc;
    logic        m_redirect_valid, m_ivalid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active         <= 1'b0;
            m_pc             <= 32'h0;
            m_redirect_valid <= 1'b0;
            m_redirect       <= 32'h0;
            m_count          <= 32'h0;
            m_instr          <= 32'h0;
            m_ipc            <= 32'h0;
            m_ivalid         <= 1'b0;
        end else if (!stall) begin
            m_active <= 1'b1;
            m_ipc    <= m_pc;
            if (m_active && imem_ready) begin
                m_pc <= m_redirect_valid ? m_redirect
                      : (branch_taken ? branch_target : m_pc + 32'd4);
                m_redirect_valid <= 1'b0;
                if (squash_in) begin
                    m_instr  <= 32'h0;
                    m_ivalid <= 1'b0;
                end else begin
                    m_instr  <= mem_word(m_pc);
                    m_ivalid <= 1'b1;
                    m_count  <= m_count + 32'd1;
                end
            end else begin
                if (branch_taken) begin
                    m_redirect_valid <= 1'b1;
                    m_redirect       <= branch_target;
                end
                m_instr  <= 32'h0;
                m_ivalid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_pc",          pc,                   m_pc);
            check("cmp_imem_addr",   imem_addr,            m_pc);
            check("cmp_imem_req",    {31'b0, imem_req},    {31'b0, m_active});
            check("cmp_if_id_instr", if_id_instr,          m_instr);
            check("cmp_if_id_pc",    if_id_pc,             m_ipc);
            check("cmp_if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ivalid});
            check("cmp_fetch_count", fetch_count,          m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, "_pc"},    pc,                   32'h0);
        check({tag, "_req"},   {31'b0, imem_req},    32'h0);
        check({tag, "_instr"}, if_id_instr,          32'h0);
        check({tag, "_ifpc"},  if_id_pc,             32'h0);
        check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        check({tag, "_count"}, fetch_count,          32'h0);
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        expect_reset_values("rst");

        // Sequential fetch from RESET_PC.
        rst_n = 1'b1;
        tick();
        check("boot_pc", pc, 32'h0);
        check("boot_valid", {31'b0, if_id_valid}, 32'h0);
        tick();
        check("seq_ifpc", if_id_pc, 32'h0);
        check("seq_instr", if_id_instr, 32'hA5A5_0000);
        check("seq_pc", pc, 32'h4);
        tick();
        check("seq_pc8", pc, 32'h8);

        // Taken branch at pc 0x8: 0x8 is the delay slot, then 0x100.
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        check("br_ds_ifpc", if_id_pc, 32'h8);
        check("br_addr", imem_addr, 32'h100);
        check("br_count3", fetch_count, 32'd3);
        tick();
        check("br_tgt_ifpc", if_id_pc, 32'h100);
        check("br_tgt_instr", if_id_instr, 32'hA5A5_0100);

        // Return to 0x8, then memory wait with a redirect to 0x200.
        branch_taken = 1'b1; branch_target = 32'h8;
        tick();
        imem_ready = 1'b0; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("wait_addr", imem_addr, 32'h8);
            check("wait_valid", {31'b0, if_id_valid}, 32'h0);
            tick();
        end
        check("wait_addr3", imem_addr, 32'h8);
        imem_ready = 1'b1;
        tick();
        check("wait_done_ifpc", if_id_pc, 32'h8);
        check("wait_redirect_pc", pc, 32'h200);
        check("wait_count", fetch_count, 32'd6);

        // Stall at 0x10; a branch presented during the stall is ignored.
        branch_taken = 1'b1; branch_target = 32'h10;
        tick();
        branch_taken = 1'b0;
        stall = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 32'h400;
        tick();
        check("stall_pc", pc, 32'h10);
        check("stall_ifpc", if_id_pc, 32'h200);
        check("stall_count", fetch_count, 32'd7);
        stall = 1'b0; branch_taken = 1'b0;
        tick();
        check("stall_rel_pc", pc, 32'h14);
        check("stall_rel_ifpc", if_id_pc, 32'h10);

`ifdef PPU_IF_SQUASH_EN
        branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        squash_in = 1'b1;
        tick();
        squash_in = 1'b0;
        check("sq_instr", if_id_instr, 32'h0);
        check("sq_valid", {31'b0, if_id_valid}, 32'h0);
        check("sq_pc", pc, 32'h24);
        check("sq_count", fetch_count, 32'd9);
`endif

        // Reset asserted mid-WAIT with a pending redirect to 0x300.
        imem_ready = 1'b0;
        tick();
        branch_taken = 1'b1; branch_target = 32'h300;
        tick();
        branch_taken = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        expect_reset_values("rst_mid");
        imem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_pc", pc, 32'h0);
        tick();
        check("post_rst_ifpc", if_id_pc, 32'h0);
        check("post_rst_pc4", pc, 32'h4);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ppu_fetch_stage
